wb_ddr_arbiter: RTL and testbench

//  Two-master Wishbone arbiter that shares the single DDR controller port between the LM32 instruction and data buses.

---
 rtl/wb_ddr_arbiter_pkg.sv | 18 +
 rtl/wb_arb_wdog.sv | 42 ++++
 rtl/wb_ddr_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_wb_ddr_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_ddr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_ddr_arbiter_pkg
// Shared definitions for the DDR-port Wishbone arbiter: FSM state encodings
// and Wishbone cycle-type-identifier (CTI) constants.
// -----------------------------------------------------------------------------
package wb_ddr_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // no slave cycle, arbitration on the next edge
      ST_BUSY = 2'd1,   // slave port owned by owner_q
      ST_TERR = 2'd2    // one-cycle watchdog termination
   } arb_state_t;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_arb_wdog.sv
// -----------------------------------------------------------------------------
// wb_arb_wdog
// Stall watchdog counter for the DDR arbiter. Counts cycles in which the slave
// strobe is up without any response and flags the last allowed cycle.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   run           strobe is up on the slave and no response this cycle
//   clear         restart the count (response, strobe low, owner change, idle)
//   expire        combinational: this is cycle TIMEOUT of a stalled strobe
// TIMEOUT = 0 disables the watchdog: the counter stays 0, expire never rises.
// -----------------------------------------------------------------------------
module wb_arb_wdog #(
   parameter int TIMEOUT = 1024,
   parameter int TMO_W   = 11
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic run,
   input  logic clear,
   output logic expire
);

   localparam bit              EN     = (TIMEOUT != 0);
   localparam int              LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [TMO_W-1:0] LAST  = TMO_W'(LAST_I);

   logic [TMO_W-1:0] cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (!EN || clear) begin
         cnt_q <= '0;
      end else if (run) begin
         cnt_q <= cnt_q + TMO_W'(1);
      end
   end

   // Expiry only when still stalled, so a response on the final cycle wins.
   assign expire = EN && run && (cnt_q == LAST);

endmodule

// File: rtl/wb_ddr_arbiter.sv
// -----------------------------------------------------------------------------
// wb_ddr_arbiter
// Two-master Wishbone arbiter sharing the single DDR controller port between
// the LM32 instruction bus (m0) and data bus (m1). Round-robin on ties, the
// owner keeps the port for its whole cyc_i, and a watchdog ends hung accesses
// with err.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   mN_*_i                master N request (adr/dat/sel/we/cti/cyc/stb)
//   mN_dat_o              slave read data, fanned out to both masters
//   mN_ack/err/rty_o      slave responses, routed to the owner only
//   s_*_o                 slave request muxed from the owner
//   s_dat_i, s_ack/err/rty_i  slave responses
//   owner_o               current / last owner index
//   timeout_o             one-cycle pulse when the watchdog fires
// -----------------------------------------------------------------------------
import wb_ddr_arbiter_pkg::*;

module wb_ddr_arbiter #(
   parameter int TIMEOUT = 1024,
   parameter int TMO_W   = 11
) (
   input  logic        clk_i,
   input  logic        rst_i,
   // master 0: instruction bus
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   output logic [31:0] m0_dat_o,
   input  logic [3:0]  m0_sel_i,
   input  logic        m0_we_i,
   input  logic [2:0]  m0_cti_i,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   output logic        m0_rty_o,
   // master 1: data bus
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   output logic [31:0] m1_dat_o,
   input  logic [3:0]  m1_sel_i,
   input  logic        m1_we_i,
   input  logic [2:0]  m1_cti_i,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic        m1_rty_o,
   // DDR slave port
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   output logic [3:0]  s_sel_o,
   output logic        s_we_o,
   output logic [2:0]  s_cti_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack_i,
   input  logic        s_err_i,
   input  logic        s_rty_i,
   // status
   output logic        owner_o,
   output logic        timeout_o
);

   arb_state_t state_q, state_d;
   logic       owner_q, owner_d;

   logic busy, terr;
   logic own_cyc, oth_cyc;
   logic s_resp;
   logic wd_run, wd_clear, wd_expire;

   assign busy    = (state_q == ST_BUSY);
   assign terr    = (state_q == ST_TERR);
   assign own_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
   assign oth_cyc = owner_q ? m0_cyc_i : m1_cyc_i;
   assign s_resp  = s_ack_i | s_err_i | s_rty_i;

   // Any cycle that is not a stalled strobe restarts the count; an owner
   // change needs the owner's cyc low, which already drops s_cyc_o.
   assign wd_run   = busy && s_cyc_o && s_stb_o && !s_resp;
   assign wd_clear = !wd_run;

   wb_arb_wdog #(
      .TIMEOUT (TIMEOUT),
      .TMO_W   (TMO_W)
   ) u_wdog (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .run    (wd_run),
      .clear  (wd_clear),
      .expire (wd_expire)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         owner_q <= 1'b1;     // m0 wins the first tie
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      case (state_q)
         ST_IDLE: begin
            if (m0_cyc_i && m1_cyc_i) begin
               owner_d = !owner_q;
               state_d = ST_BUSY;
            end else if (m0_cyc_i) begin
               owner_d = 1'b0;
               state_d = ST_BUSY;
            end else if (m1_cyc_i) begin
               owner_d = 1'b1;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (wd_expire) begin
               state_d = ST_TERR;
            end else if (!own_cyc) begin
               // Direct handover avoids an idle bubble when the other waits.
               if (oth_cyc) begin
                  owner_d = !owner_q;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_TERR: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Slave-side request mux; everything is held at 0 outside BUSY.
   always_comb begin
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      s_we_o  = 1'b0;
      s_cti_o = '0;
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      if (busy) begin
         if (owner_q) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
            s_we_o  = m1_we_i;
            s_cti_o = m1_cti_i;
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_stb_i;
         end else begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
            s_we_o  = m0_we_i;
            s_cti_o = m0_cti_i;
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_stb_i;
         end
      end
   end

   // Responses only reach the owner and only while BUSY; the watchdog err
   // is generated during the TERR cycle.
   assign m0_ack_o = busy && !owner_q && s_ack_i;
   assign m0_rty_o = busy && !owner_q && s_rty_i;
   assign m0_err_o = !owner_q && ((busy && s_err_i) || terr);
   assign m1_ack_o = busy && owner_q && s_ack_i;
   assign m1_rty_o = busy && owner_q && s_rty_i;
   assign m1_err_o = owner_q && ((busy && s_err_i) || terr);

   assign m0_dat_o  = s_dat_i;
   assign m1_dat_o  = s_dat_i;
   assign owner_o   = owner_q;
   assign timeout_o = terr;

endmodule

// File: tb/tb_wb_ddr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_ddr_arbiter
// Directed bench for wb_ddr_arbiter (TIMEOUT=16). Expected master-side
// responses are queued when the slave stimulus is applied; a negedge monitor
// pops and compares whenever any response or timeout_o is visible.
// -----------------------------------------------------------------------------
module tb_wb_ddr_arbiter;
   import wb_ddr_arbiter_pkg::*;

   localparam int TMO = 16;

   localparam logic [6:0] R_M0_ACK = 7'h01;
   localparam logic [6:0] R_M0_ERR = 7'h02;
   localparam logic [6:0] R_M1_ACK = 7'h08;
   localparam logic [6:0] R_TMO    = 7'h40;

   localparam logic [31:0] A0 = 32'h4000_0010;
   localparam logic [31:0] A1 = 32'h4000_0200;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic [31:0] m0_adr_i = '0, m0_dat_i = '0, m0_dat_o;
   logic [3:0]  m0_sel_i = '0;
   logic        m0_we_i = 1'b0, m0_cyc_i = 1'b0, m0_stb_i = 1'b0;
   logic [2:0]  m0_cti_i = '0;
   logic        m0_ack_o, m0_err_o, m0_rty_o;
   logic [31:0] m1_adr_i = '0, m1_dat_i = '0, m1_dat_o;
   logic [3:0]  m1_sel_i = '0;
   logic        m1_we_i = 1'b0, m1_cyc_i = 1'b0, m1_stb_i = 1'b0;
   logic [2:0]  m1_cti_i = '0;
   logic        m1_ack_o, m1_err_o, m1_rty_o;
   logic [31:0] s_adr_o, s_dat_o, s_dat_i = '0;
   logic [3:0]  s_sel_o;
   logic        s_we_o, s_cyc_o, s_stb_o;
   logic [2:0]  s_cti_o;
   logic        s_ack_i = 1'b0, s_err_i = 1'b0, s_rty_i = 1'b0;
   logic        owner_o, timeout_o;

   typedef struct packed {
      logic [6:0]  resp;
      logic [31:0] dat;
   } exp_t;

   exp_t sb_q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   wb_ddr_arbiter #(.TIMEOUT(TMO), .TMO_W(5)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
      .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i), .m0_cti_i(m0_cti_i),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
      .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
      .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
      .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i), .m1_cti_i(m1_cti_i),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
      .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
      .s_cti_o(s_cti_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
      .owner_o(owner_o), .timeout_o(timeout_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_total++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got %h, required %h", name, act, exp_v);
   endtask

   task automatic push_exp(input logic [6:0] r, input logic [31:0] d);
      exp_t e;
      e.resp = r;
      e.dat  = d;
      sb_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic m0_drive(input logic cyc, input logic stb, input logic [31:0] adr,
                           input logic [2:0] cti);
      m0_cyc_i = cyc; m0_stb_i = stb; m0_adr_i = adr; m0_cti_i = cti;
      m0_sel_i = 4'hF; m0_we_i = 1'b0; m0_dat_i = 32'h0;
   endtask

   task automatic m1_drive(input logic cyc, input logic stb, input logic [31:0] adr,
                           input logic [2:0] cti);
      m1_cyc_i = cyc; m1_stb_i = stb; m1_adr_i = adr; m1_cti_i = cti;
      m1_sel_i = 4'hF; m1_we_i = 1'b0; m1_dat_i = 32'h0;
   endtask

   // Response monitor
   always @(negedge clk) begin
      logic [6:0] r;
      exp_t       e;
      r = {timeout_o, m1_rty_o, m1_err_o, m1_ack_o, m0_rty_o, m0_err_o, m0_ack_o};
      if (r != 7'h0) begin
         n_total++;
         if (sb_q.size() == 0) begin
            $display("FAIL unexpected_resp: got resp=%b, required no response", r);
         end else begin
            e = sb_q.pop_front();
            if (r == e.resp && m0_dat_o == e.dat && m1_dat_o == e.dat) n_pass++;
            else $display("FAIL resp: got resp=%b dat=%h/%h, required resp=%b dat=%h",
                          r, m0_dat_o, m1_dat_o, e.resp, e.dat);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish, required finish before 100us");
      $fatal(1);
   end

   initial begin
      int n;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s_cyc", 32'(s_cyc_o), 0);
      chk("rst_s_stb", 32'(s_stb_o), 0);
      chk("rst_owner", 32'(owner_o), 1);
      chk("rst_timeout", 32'(timeout_o), 0);
      chk("rst_s_adr", s_adr_o, 0);
      rst_i = 1'b0;
      tick();

      // single-master read
      m0_drive(1'b1, 1'b1, A0, CTI_CLASSIC);
      @(negedge clk);
      chk("t1_no_grant_yet", 32'(s_cyc_o), 0);
      tick();
      @(negedge clk);
      chk("t1_s_cyc", 32'(s_cyc_o), 1);
      chk("t1_s_adr", s_adr_o, A0);
      chk("t1_owner", 32'(owner_o), 0);
      tick();
      s_dat_i = 32'hDEAD_BEEF; s_ack_i = 1'b1;
      push_exp(R_M0_ACK, 32'hDEAD_BEEF);
      tick();
      s_ack_i = 1'b0; s_dat_i = '0;
      m0_drive(1'b0, 1'b0, A0, CTI_CLASSIC);
      tick();
      @(negedge clk);
      chk("t1_idle", 32'(s_cyc_o), 0);

      // tie after reset
      rst_i = 1'b1;
      #2;
      rst_i = 1'b0;
      tick();
      m0_drive(1'b1, 1'b1, A0, CTI_CLASSIC);
      m1_drive(1'b1, 1'b1, A1, CTI_CLASSIC);
      tick();
      @(negedge clk);
      chk("t2_tie_owner", 32'(owner_o), 0);
      chk("t2_tie_adr", s_adr_o, A0);
      tick();
      s_dat_i = 32'h1111_1111; s_ack_i = 1'b1;
      push_exp(R_M0_ACK, 32'h1111_1111);
      tick();
      s_ack_i = 1'b0;
      m0_drive(1'b0, 1'b0, A0, CTI_CLASSIC);
      tick();
      s_dat_i = 32'h2222_2222; s_ack_i = 1'b1;
      push_exp(R_M1_ACK, 32'h2222_2222);
      @(negedge clk);
      chk("t2_handover_owner", 32'(owner_o), 1);
      chk("t2_handover_cyc", 32'(s_cyc_o), 1);
      chk("t2_handover_adr", s_adr_o, A1);
      tick();
      s_ack_i = 1'b0;
      m1_drive(1'b0, 1'b0, A1, CTI_CLASSIC);
      tick();
      @(negedge clk);
      chk("t2_idle", 32'(s_cyc_o), 0);
      m0_drive(1'b1, 1'b1, A0, CTI_CLASSIC);
      m1_drive(1'b1, 1'b1, A1, CTI_CLASSIC);
      tick();
      @(negedge clk);
      chk("t2_second_tie_owner", 32'(owner_o), 0);
      tick();
      m0_drive(1'b0, 1'b0, A0, CTI_CLASSIC);
      m1_drive(1'b0, 1'b0, A1, CTI_CLASSIC);
      tick();

      // burst hold: m1 4-beat incrementing burst while m0 waits
      m1_drive(1'b1, 1'b1, A1, CTI_INCR);
      tick();
      m0_drive(1'b1, 1'b1, A0, CTI_CLASSIC);
      for (int i = 0; i < 4; i++) begin
         m1_drive(1'b1, 1'b1, A1 + 32'(4 * i), (i == 3) ? CTI_EOB : CTI_INCR);
         s_dat_i = 32'h3000_0000 + 32'(i); s_ack_i = 1'b1;
         push_exp(R_M1_ACK, 32'h3000_0000 + 32'(i));
         @(negedge clk);
         chk("t3_beat_owner", 32'(owner_o), 1);
         chk("t3_beat_adr", s_adr_o, A1 + 32'(4 * i));
         if (i == 0) chk("t3_cti", 32'(s_cti_o), 32'(CTI_INCR));
         tick();
      end
      s_ack_i = 1'b0;
      m1_drive(1'b0, 1'b0, A1, CTI_CLASSIC);
      @(negedge clk);
      chk("t3_hold_until_cyc_falls", 32'(owner_o), 1);
      tick();
      s_dat_i = 32'h4444_4444; s_ack_i = 1'b1;
      push_exp(R_M0_ACK, 32'h4444_4444);
      @(negedge clk);
      chk("t3_m0_granted", 32'(owner_o), 0);
      chk("t3_m0_adr", s_adr_o, A0);
      tick();
      s_ack_i = 1'b0; s_dat_i = '0;
      m0_drive(1'b0, 1'b0, A0, CTI_CLASSIC);
      tick();

      // watchdog: slave never responds
      m0_drive(1'b1, 1'b1, A0, CTI_CLASSIC);
      push_exp(R_TMO | R_M0_ERR, 32'h0);
      tick();
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (s_stb_o) n++;
         else break;
      end
      chk("t4_stb_cycles", 32'(n), TMO);
      chk("t4_terr_cyc", 32'(s_cyc_o), 0);
      chk("t4_terr_timeout", 32'(timeout_o), 1);
      chk("t4_terr_err", 32'(m0_err_o), 1);
      m0_drive(1'b0, 1'b0, A0, CTI_CLASSIC);
      @(negedge clk);
      chk("t4_after_cyc", 32'(s_cyc_o), 0);
      chk("t4_after_timeout", 32'(timeout_o), 0);
      tick();

      // race: ack on the expiry cycle
      m0_drive(1'b1, 1'b1, A0 + 32'h8, CTI_CLASSIC);
      tick();
      repeat (TMO - 1) tick();
      s_dat_i = 32'h55AA_55AA; s_ack_i = 1'b1;
      push_exp(R_M0_ACK, 32'h55AA_55AA);
      @(negedge clk);
      chk("t5_race_cyc", 32'(s_cyc_o), 1);
      chk("t5_race_no_timeout", 32'(timeout_o), 0);
      tick();
      s_ack_i = 1'b0; s_dat_i = '0;
      m0_drive(1'b0, 1'b0, A0, CTI_CLASSIC);
      @(negedge clk);
      chk("t5_after_no_timeout", 32'(timeout_o), 0);
      chk("t5_after_no_err", 32'(m0_err_o), 0);
      tick();

      // asynchronous reset in the middle of a burst
      m0_drive(1'b1, 1'b1, A0, CTI_INCR);
      tick();
      chk("t6_busy_cyc", 32'(s_cyc_o), 1);
      chk("t6_owner_pre", 32'(owner_o), 0);
      #1;
      rst_i = 1'b1;
      s_ack_i = 1'b1;
      #1;
      chk("t6_rst_cyc", 32'(s_cyc_o), 0);
      chk("t6_rst_ack", 32'(m0_ack_o), 0);
      chk("t6_rst_owner", 32'(owner_o), 1);
      @(negedge clk);
      s_ack_i = 1'b0;
      m0_drive(1'b0, 1'b0, A0, CTI_CLASSIC);
      tick();
      rst_i = 1'b0;
      @(negedge clk);
      chk("t6_release_cyc", 32'(s_cyc_o), 0);
      chk("t6_release_owner", 32'(owner_o), 1);
      tick();
      @(negedge clk);
      chk("t6_idle", 32'(s_cyc_o), 0);

      tick();
      chk("sb_drained", 32'(sb_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
